uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers. It captures a winning requester's byte and issues a single-cycle valid to the transmitter. It then tracks the transmitter's busy flag through the whole frame before it grants again. It sits between the producers and the TX control unit, and it never issues while the transmitter is busy, so the TX data-lost condition cannot occur.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width per requester
TIMEOUT_CYCLES, 64, max cycles waiting for tx_busy to rise (used only with TXARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; data must stay stable while req is high
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i has been captured
tx_data  out  DATA_WIDTH  registered byte driven to the transmitter
tx_valid  out  1  one-cycle issue strobe to the transmitter
tx_busy  in  1  transmitter busy flag (registered in the TX, rises about 2 cycles after tx_valid)
grant_id  out  clog2(NUM_REQ)  index of the current owner; valid while arb_busy=1
arb_busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on watchdog expiry (tied 0 without the macro)

Behaviour:
- Reset (async, rst=0):
  - State=IDLE.
  - ack=0, tx_valid=0, tx_data=0, grant_id=0, arb_busy=0, timeout_err=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
- A reset mid-frame abandons the transaction: no ack, no tx_valid. Producers must re-request.
- States:
  - IDLE: if |req, pick the winner w = first set bit of req, searching last+1, last+2, ... with wrap modulo NUM_REQ. On that edge register grant_id=w, tx_data=req_data[w], last=w. Go to ISSUE. With no request, remain in IDLE.
  - ISSUE (exactly 1 cycle): tx_valid=1 and ack[w]=1 in the same cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: hold until tx_busy=1, then go to WAIT_IDLE.
  - WAIT_IDLE: hold until tx_busy=0, then go to IDLE.
- Latency:
  - req high in IDLE -> tx_valid/ack 1 cycle later.
  - tx_busy falling -> WAIT_IDLE->IDLE on the next edge -> earliest next tx_valid 2 cycles after tx_busy drops.
- Requester handshake:
  - After ack, the requester may drop req or present its next byte in the following cycle.
  - A req dropped before it is granted is simply not considered. No ack is owed.
  - Requests that arrive during WAIT_* are sampled only on return to IDLE.
- Fairness: a continuously requesting source is served at most once per full rotation while others request. With a single requester, it is served back to back.
- tx_valid is never asserted while tx_busy=1 or in any state other than ISSUE.
- Simultaneous events:
  - tx_busy already 1 in ISSUE cycle: not checked in ISSUE; WAIT_BUSY sees it on the next cycle and advances.
  - tx_busy high and low within WAIT_BUSY is not possible; the TX busy lasts at least 2 cycles.
- Illegal state encodings return to IDLE with all strobes low.

Optional Feature:
TXARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle there.
  - If tx_busy is still 0 when the count reaches TIMEOUT_CYCLES-1, pulse timeout_err for 1 cycle and go to IDLE. The pointer is already advanced, and the byte counts as consumed (ack was given).
  - Counter width is clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter. WAIT_BUSY waits indefinitely. timeout_err is constant 0.

Test Plan:
1. Reset then req=4'b0001, req_data[7:0]=8'hA5 -> one cycle later tx_valid=1, tx_data=8'hA5, ack=4'b0001, grant_id=0. TX model raises busy 2 cycles later for 10 cycles; next tx_valid no earlier than 2 cycles after busy falls.
2. req=4'b1111 held continuously -> grant order 0,1,2,3,0; each ack is a single-cycle pulse; tx_valid count equals ack count.
3. After a grant to 2, req=4'b0101 -> next grant is 0 (wrap past 3). Then with req=4'b0101 still high -> grant 2.
4. req[1] raised then dropped while the arbiter is in WAIT_IDLE serving 0 -> ack[1] never pulses. Assert tx_valid never coincides with tx_busy=1 over a 10k-cycle random run.
5. rst pulsed low while in WAIT_IDLE -> all outputs 0 immediately (async). The next grant after release goes to the lowest-index requester.
6. With TXARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, TX model never raises busy -> timeout_err pulses exactly 64 cycles after entering WAIT_BUSY. Arbiter is back in IDLE and grants the next requester. Without the macro: stays in WAIT_BUSY and timeout_err=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ producers; grant->tx_valid/ack 1 cycle, next grant 2 cycles after tx_busy falls.
// Holds off new grants for the whole TX frame; define TXARB_TIMEOUT_EN to add the tx_busy-rise watchdog.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_valid,
   input  logic                          tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          arb_busy,
   output logic                          timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;

   state_t                 state_q, state_d;
   logic [IDW-1:0]         last_q, last_d;
   logic [IDW-1:0]         grant_q, grant_d;
   logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   found;
   logic [IDW-1:0]         win;
   logic [IDW-1:0]         rr_idx;
   logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

`ifdef TXARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   timeout_q, timeout_d;
`endif

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search starts just after the last winner, so the previous owner ranks lowest.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      rr_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = IDW'((int'(last_q) + k) % NUM_REQ);
         if (!found && req[rr_idx]) begin
            found = 1'b1;
            win   = rr_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      tx_data_d  = tx_data_q;
      ack_d      = '0;
      tx_valid_d = 1'b0;
`ifdef TXARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = ISSUE;
               grant_d      = win;
               last_d       = win;
               tx_data_d    = req_bytes[win];
               tx_valid_d   = 1'b1;
               ack_d[win]   = 1'b1;
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
`ifdef TXARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_IDLE;
`ifdef TXARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // The byte was already acked, so it is dropped rather than retried.
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         WAIT_IDLE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_q     <= IDW'(NUM_REQ - 1);
         grant_q    <= '0;
         tx_data_q  <= '0;
         ack_q      <= '0;
         tx_valid_q <= 1'b0;
`ifdef TXARB_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         tx_data_q  <= tx_data_d;
         ack_q      <= ack_d;
         tx_valid_q <= tx_valid_d;
`ifdef TXARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign ack      = ack_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign grant_id = grant_q;
   assign arb_busy = (state_q != IDLE);
`ifdef TXARB_TIMEOUT_EN
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for grant order plus hand sequences and a TX busy model.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [31:0] req_data = 32'h3322_11A5;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   // TX model state
   bit model_clr = 1'b1;
   bit tx_en     = 1'b1;
   int tx_len    = 10;
   int rise_cnt  = 0;
   int busy_cnt  = 0;

   // monitor state
   int valid_cnt = 0;
   int ack_total = 0;
   int ack_cnt [4] = '{0, 0, 0, 0};
   int tout_cnt  = 0;
   bit prev_idle = 1'b1;
   int mdl_last  = 3;

   typedef struct {
      logic [3:0] req;
      logic [1:0] gnt;
      logic [3:0] ack;
      logic [7:0] data;
   } vec_t;
   vec_t vecs [13];

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond(input int what);
      case (what)
         0:       return tx_busy == 1'b1;
         1:       return tx_busy == 1'b0;
         2:       return tx_valid == 1'b1;
         default: return (arb_busy == 1'b0) && (tx_busy == 1'b0);
      endcase
   endfunction

   task automatic wait_for(input int what, input int budget, input string name);
      int n = 0;
      while (!cond(what) && n < budget) begin
         step();
         n++;
      end
      chk(name, 32'(cond(what)), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      model_clr = 1'b1;
      repeat (2) step();
      @(negedge clk);
      rst = 1'b1;
      model_clr = 1'b0;
   endtask

   // TX model: busy rises on the 2nd falling edge after tx_valid and stays up for tx_len cycles.
   always @(negedge clk) begin
      if (model_clr) begin
         tx_busy  = 1'b0;
         rise_cnt = 0;
         busy_cnt = 0;
      end else begin
         if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
               tx_busy  = 1'b1;
               busy_cnt = tx_len;
            end
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
         if (tx_valid && tx_en) rise_cnt = 2;
      end
   end

   // Scoreboard: predicts every issue from the request vector seen while the arbiter was idle.
   always @(posedge clk) begin
      bit exp_v;
      int w;
      #1;
      if (tx_valid) valid_cnt++;
      for (int i = 0; i < 4; i++) begin
         if (ack[i]) begin
            ack_cnt[i]++;
            ack_total++;
         end
      end
      if (timeout_err) tout_cnt++;
      if (!rst) begin
         mdl_last  = 3;
         prev_idle = 1'b1;
      end else begin
         exp_v = prev_idle && (req != 4'b0000);
         w = -1;
         if (exp_v) begin
            for (int k = 1; k <= 4; k++) begin
               if (w < 0 && ((req >> ((mdl_last + k) % 4)) & 4'd1) != 4'd0) w = (mdl_last + k) % 4;
            end
            mdl_last = w;
            chk("mon_ack", 32'(ack), 32'd1 << w);
            chk("mon_grant", 32'(grant_id), 32'(w));
            chk("mon_tx_data", 32'(tx_data), 32'(req_data[w*8 +: 8]));
         end else begin
            chk("mon_ack_idle", 32'(ack), 32'd0);
         end
         chk("mon_tx_valid", 32'(tx_valid), 32'(exp_v));
         chk("mon_valid_while_busy", 32'(tx_valid & tx_busy), 32'd0);
         prev_idle = !arb_busy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1;
      int n;
      int v0;
      vecs[0]  = '{4'b1111, 2'd0, 4'b0001, 8'hA5};
      vecs[1]  = '{4'b1111, 2'd1, 4'b0010, 8'h11};
      vecs[2]  = '{4'b1111, 2'd2, 4'b0100, 8'h22};
      vecs[3]  = '{4'b1111, 2'd3, 4'b1000, 8'h33};
      vecs[4]  = '{4'b1111, 2'd0, 4'b0001, 8'hA5};
      vecs[5]  = '{4'b0100, 2'd2, 4'b0100, 8'h22};
      vecs[6]  = '{4'b0101, 2'd0, 4'b0001, 8'hA5};
      vecs[7]  = '{4'b0101, 2'd2, 4'b0100, 8'h22};
      vecs[8]  = '{4'b1000, 2'd3, 4'b1000, 8'h33};
      vecs[9]  = '{4'b1000, 2'd3, 4'b1000, 8'h33};
      vecs[10] = '{4'b0011, 2'd0, 4'b0001, 8'hA5};
      vecs[11] = '{4'b0010, 2'd1, 4'b0010, 8'h11};
      vecs[12] = '{4'b1110, 2'd2, 4'b0100, 8'h22};

      // reset state
      repeat (2) step();
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_arb_busy", 32'(arb_busy), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_clr = 1'b0;
      step();
      chk("idle_no_req", 32'(arb_busy), 32'd0);

      // first transaction latency and re-grant spacing
      tx_len = 10;
      @(negedge clk);
      req = 4'b0001;
      step();
      chk("t1_valid_1cyc", 32'(tx_valid), 32'd1);
      chk("t1_data", 32'(tx_data), 32'hA5);
      chk("t1_ack", 32'(ack), 32'b0001);
      chk("t1_grant", 32'(grant_id), 32'd0);
      chk("t1_arb_busy", 32'(arb_busy), 32'd1);
      step();
      chk("t1_ack_pulse", 32'(ack), 32'd0);
      chk("t1_valid_pulse", 32'(tx_valid), 32'd0);
      wait_for(0, 10, "t1_busy_rise");
      wait_for(1, 20, "t1_busy_fall");
      chk("t1_no_early_valid", 32'(tx_valid), 32'd0);
      step();
      chk("t1_valid_2cyc_after_fall", 32'(tx_valid), 32'd1);
      chk("t1_back_to_back_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      req = 4'b0000;
      wait_for(3, 40, "t1_idle");

      // grant order table
      do_reset();
      tx_len = 3;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         req = vecs[i].req;
         wait_for(2, 40, $sformatf("tbl%0d_valid", i));
         chk($sformatf("tbl%0d_grant", i), 32'(grant_id), 32'(vecs[i].gnt));
         chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
         chk($sformatf("tbl%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
         step();
         chk($sformatf("tbl%0d_ack_pulse", i), 32'(ack), 32'd0);
      end
      @(negedge clk);
      req = 4'b0000;
      wait_for(3, 40, "tbl_idle");

      // request raised and dropped during WAIT_IDLE earns no ack
      tx_len = 10;
      a1 = ack_cnt[1];
      @(negedge clk);
      req = 4'b0001;
      wait_for(2, 40, "t4_valid");
      chk("t4_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      req = 4'b0000;
      wait_for(0, 10, "t4_busy_rise");
      @(negedge clk);
      req = 4'b0010;
      repeat (2) @(negedge clk);
      req = 4'b0000;
      step();
      chk("t4_still_busy", 32'(tx_busy & arb_busy), 32'd1);
      wait_for(3, 40, "t4_idle");
      repeat (3) step();
      chk("t4_no_ack1", 32'(ack_cnt[1]), 32'(a1));

      // async reset while in WAIT_IDLE
      @(negedge clk);
      req = 4'b0001;
      wait_for(2, 40, "t5_valid");
      @(negedge clk);
      req = 4'b0000;
      wait_for(0, 10, "t5_busy_rise");
      chk("t5_arb_busy_before", 32'(arb_busy), 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_clr = 1'b1;
      req = 4'b1010;
      #1;
      chk("t5_async_tx_data", 32'(tx_data), 32'd0);
      chk("t5_async_arb_busy", 32'(arb_busy), 32'd0);
      chk("t5_async_ack", 32'(ack), 32'd0);
      chk("t5_async_valid", 32'(tx_valid), 32'd0);
      repeat (2) step();
      @(negedge clk);
      rst = 1'b1;
      model_clr = 1'b0;
      wait_for(2, 5, "t5_valid_after_rst");
      chk("t5_grant_lowest", 32'(grant_id), 32'd1);
      chk("t5_ack", 32'(ack), 32'b0010);
      chk("t5_data", 32'(tx_data), 32'h11);
      @(negedge clk);
      req = 4'b0000;
      wait_for(3, 40, "t5_idle");

      // transmitter never raises busy
      tx_en = 1'b0;
      @(negedge clk);
      req = 4'b0100;
      wait_for(2, 40, "t6_valid");
      chk("t6_grant", 32'(grant_id), 32'd2);
      v0 = valid_cnt;
      @(negedge clk);
      req = 4'b0000;
`ifdef TXARB_TIMEOUT_EN
      n = 0;
      while (!timeout_err && n < 100) begin
         step();
         n++;
      end
      chk("t6_timeout_latency", 32'(n), 32'd65);
      chk("t6_idle_after_timeout", 32'(arb_busy), 32'd0);
      step();
      chk("t6_timeout_pulse", 32'(timeout_err), 32'd0);
      tx_en = 1'b1;
      @(negedge clk);
      req = 4'b1000;
      wait_for(2, 40, "t6_next_valid");
      chk("t6_next_grant", 32'(grant_id), 32'd3);
      @(negedge clk);
      req = 4'b0000;
      wait_for(3, 40, "t6_idle");
`else
      n = 0;
      repeat (80) begin
         step();
         n++;
      end
      chk("t6_stuck_wait_busy", 32'(arb_busy), 32'd1);
      chk("t6_no_timeout", 32'(tout_cnt), 32'd0);
      chk("t6_no_reissue", 32'(valid_cnt), 32'(v0));
      do_reset();
      tx_en = 1'b1;
`endif

      // random traffic, scoreboard checks every cycle
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         req = 4'($urandom_range(0, 15));
         tx_len = $urandom_range(2, 6);
      end
      @(negedge clk);
      req = 4'b0000;
      wait_for(3, 40, "rnd_idle");
      chk("valid_count_eq_ack_count", 32'(valid_cnt), 32'(ack_total));
`ifdef TXARB_TIMEOUT_EN
      chk("timeout_total", 32'(tout_cnt), 32'd1);
`else
      chk("timeout_total", 32'(tout_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
